key_sdram_tester: RTL and testbench
===================================

// Module: key_sdram_tester
// PURPOSE
//  Consumer of the debounced key pulse (key_vld, one clk wide) inside sdram_top.
//  Each accepted press launches one SDRAM burst test step, alternating between two operations:
//  - Press 1: write a pattern burst.
//  - Press 2: read the burst back and compare it.
//  Drives the SDRAM controller user port with a req/ack handshake and reports a sticky error flag.
// PARAMETERS
//  ADDR_W        24     user-port address width
//  DATA_W        16     user-port data width
//  BURST_LEN     8      words per burst (2..256)
//  PATTERN_SEED  16'h5A00  base value of the data pattern
// PORTS
//  clk          in   1       system clock, 100 MHz
//  rst_n        in   1       async active-low reset
//  key_vld      in   1       debounced press pulse, 1 clk
//  wr_req       out  1       write burst request, held until wr_ack
//  wr_ack       in   1       controller accepted the write request
//  wr_addr      out  ADDR_W  write burst start address
//  wr_data_req  in   1       controller consumes wr_data this cycle
//  wr_data      out  DATA_W  write word; valid combinationally with wr_data_req
//  wr_done      in   1       write burst finished (1-clk pulse)
//  rd_req       out  1       read burst request, held until rd_ack
//  rd_ack       in   1       controller accepted the read request
//  rd_addr      out  ADDR_W  read burst start address
//  rd_data      in   DATA_W  read word
//  rd_data_vld  in   1       rd_data is valid
//  rd_done      in   1       read burst finished (1-clk pulse)
//  busy         out  1       1 in any state other than IDLE
//  next_rd      out  1       0: next press writes; 1: next press reads
//  err          out  1       sticky compare/protocol error
// BEHAVIOUR
//  Reset values: all outputs 0, FSM=IDLE, idx=0, pass=0, base=0.
//  FSM:
//  - IDLE -> WREQ: key_vld && !next_rd.
//  - IDLE -> RREQ: key_vld && next_rd.
//  - WREQ -> WBST: wr_ack.
//  - WBST -> IDLE: wr_done; set next_rd=1.
//  - RREQ -> RBST: rd_ack.
//  - RBST -> IDLE: rd_done; set next_rd=0; pass<=pass+1 (8 bit, wraps).
//  Request timing:
//  - wr_req/rd_req are registered: rise 1 clk after key_vld.
//  - They stay 1 through the ack cycle and drop the cycle after.
//  - key_vld while busy=1 is dropped: no queueing, no error.
//  Address: wr_addr=rd_addr=base, stable from request until done.
//  Data pattern:
//  - pat(i) = PATTERN_SEED + pass + i, taken mod 2^DATA_W.
//  - wr_data = pat(idx).
//  - idx increments on each wr_data_req or rd_data_vld; idx clears on entering WREQ/RREQ.
//  Compare: each rd_data_vld with rd_data != pat(idx) sets err.
//  Count errors: err is set if any of the following occurs:
//  - wr_data_req when idx==BURST_LEN (idx holds; wr_data repeats the last word).
//  - rd_data_vld when idx==BURST_LEN.
//  - wr_done/rd_done with idx != BURST_LEN.
//  Stray signals:
//  - wr_done in WREQ, or rd_done in RREQ: ignored.
//  - ack outside its own REQ state: ignored.
//  Reset mid-burst: immediate return to reset values; no partial state survives.
//  err stays set until rst_n.
// CONFIGURATION
//  KEY_SDRAM_TESTER_ADDR_INC_EN:
//  - Defined: after each rd_done, base <= base + BURST_LEN mod 2^ADDR_W, so the next write/read pair tests a new region.
//  - Undefined: base is fixed at 0.
// TESTING
//  - Press, wr_ack after 3 clk, 8 wr_data_req, wr_done -> wr_req high 1 clk after key_vld; data 5A00..5A07; next_rd=1; err=0.
//  - Press, rd_ack, return 5A00..5A07, rd_done -> err=0; pass=1; next write emits 5A01..5A08.
//  - Read back with word 3 = 5A13 -> err=1, and it stays 1 through later clean passes until rst_n.
//  - key_vld pulses during WBST and RBST -> ignored; exactly one burst per accepted press.
//  - rd_done after only 7 rd_data_vld -> err=1; a 9th wr_data_req -> err=1 and wr_data repeats 5A07.
//  - Assert rst_n=0 mid-WBST -> wr_req=0, busy=0, next_rd=0 immediately.
//  - With ADDR_INC_EN: two write/read pairs -> second pair uses addr 8.

Source files
------------

// File: rtl/key_sdram_tester.sv
// Key-driven SDRAM burst tester: alternates write-pattern and read-compare bursts on each accepted press.
// Optional macro KEY_SDRAM_TESTER_ADDR_INC_EN advances the burst base address after every read burst.
module key_sdram_tester #(
    parameter int                ADDR_W       = 24,
    parameter int                DATA_W       = 16,
    parameter int                BURST_LEN    = 8,
    parameter logic [DATA_W-1:0] PATTERN_SEED = 16'h5A00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_vld,
    output logic              wr_req,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data_req,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_data_vld,
    input  logic              rd_done,
    output logic              busy,
    output logic              next_rd,
    output logic              err
);

    localparam int              IDX_W    = $clog2(BURST_LEN + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WREQ = 3'd1;
    localparam logic [2:0] S_WBST = 3'd2;
    localparam logic [2:0] S_RREQ = 3'd3;
    localparam logic [2:0] S_RBST = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        pass_q, pass_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              next_rd_q, next_rd_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  wr_idx;

    function automatic logic [DATA_W-1:0] pat(input logic [7:0] p, input logic [IDX_W-1:0] i);
        return PATTERN_SEED + DATA_W'(p) + DATA_W'(i);
    endfunction

    // Overrun write requests keep replaying the final word of the burst.
    assign wr_idx  = (idx_q == IDX_LAST) ? IDX_LAST - IDX_W'(1) : idx_q;
    assign wr_data = (state_q == S_WBST) ? pat(pass_q, wr_idx) : '0;
    assign wr_req  = wr_req_q;
    assign rd_req  = rd_req_q;
    assign wr_addr = base_q;
    assign rd_addr = base_q;
    assign busy    = (state_q != S_IDLE);
    assign next_rd = next_rd_q;
    assign err     = err_q;

    always_comb begin
        state_d   = state_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        base_d    = base_q;
        next_rd_d = next_rd_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (key_vld) begin
                    idx_d = '0;
                    if (next_rd_q) begin
                        state_d  = S_RREQ;
                        rd_req_d = 1'b1;
                    end else begin
                        state_d  = S_WREQ;
                        wr_req_d = 1'b1;
                    end
                end
            end
            S_WREQ: begin
                if (wr_ack) begin
                    state_d  = S_WBST;
                    wr_req_d = 1'b0;
                end
            end
            S_WBST: begin
                if (wr_data_req) begin
                    if (idx_q == IDX_LAST) err_d = 1'b1;
                    else                   idx_d = idx_q + IDX_W'(1);
                end
                if (wr_done) begin
                    if (idx_q != IDX_LAST) err_d = 1'b1;
                    state_d   = S_IDLE;
                    next_rd_d = 1'b1;
                end
            end
            S_RREQ: begin
                if (rd_ack) begin
                    state_d  = S_RBST;
                    rd_req_d = 1'b0;
                end
            end
            S_RBST: begin
                if (rd_data_vld) begin
                    if (idx_q == IDX_LAST) begin
                        err_d = 1'b1;
                    end else begin
                        if (rd_data != pat(pass_q, idx_q)) err_d = 1'b1;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                if (rd_done) begin
                    if (idx_q != IDX_LAST) err_d = 1'b1;
                    state_d   = S_IDLE;
                    next_rd_d = 1'b0;
                    pass_d    = pass_q + 8'd1;
`ifdef KEY_SDRAM_TESTER_ADDR_INC_EN
                    base_d    = base_q + ADDR_W'(BURST_LEN);
`else
                    base_d    = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            idx_q     <= '0;
            pass_q    <= '0;
            base_q    <= '0;
            next_rd_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            idx_q     <= idx_d;
            pass_q    <= pass_d;
            base_q    <= base_d;
            next_rd_q <= next_rd_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_key_sdram_tester.sv
// Bench for key_sdram_tester: table-driven write/read steps, corner sequences, then random steps vs a model.
module tb_key_sdram_tester;

    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_vld, wr_ack, wr_data_req, wr_done;
    logic        rd_ack, rd_data_vld, rd_done;
    logic [15:0] rd_data;
    logic        wr_req, rd_req, busy, next_rd, err;
    logic [23:0] wr_addr, rd_addr;
    logic [15:0] wr_data;

    int n_chk  = 0;
    int n_fail = 0;

    // high-level model of what the tester should have done so far
    int m_pass;
    int m_base;
    bit m_next_rd;
    bit m_err;

    key_sdram_tester dut (
        .clk(clk), .rst_n(rst_n), .key_vld(key_vld),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr),
        .wr_data_req(wr_data_req), .wr_data(wr_data), .wr_done(wr_done),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_done(rd_done),
        .busy(busy), .next_rd(next_rd), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_rd;
        int ack_dly;
        int nwords;
        int corrupt;
        bit noise;
        bit exp_err;
        bit exp_next_rd;
    } vec_t;

    function automatic logic [15:0] tpat(input int p, input int i);
        return 16'((32'h5A00 + (p % 256) + i) % 65536);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pass = 0; m_base = 0; m_next_rd = 0; m_err = 0;
    endtask

    task automatic do_write(input int ack_dly, input int nwords, input bit noise);
        chk("wr_req_before_press", {31'd0, wr_req}, 0);
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        chk("wr_req_rise", {31'd0, wr_req}, 1);
        chk("wr_addr", wr_addr, m_base);
        for (int j = 0; j < ack_dly; j++) begin
            wr_done = noise && (j == 0);
            @(negedge clk);
            wr_done = 1'b0;
            chk("wr_req_hold", {31'd0, wr_req}, 1);
        end
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        chk("wr_req_drop", {31'd0, wr_req}, 0);
        chk("busy_wbst", {31'd0, busy}, 1);
        for (int i = 0; i < nwords; i++) begin
            wr_data_req = 1'b1;
            key_vld = noise && (i == 2);
            chk("wr_data", wr_data, tpat(m_pass, (i < BL) ? i : BL - 1));
            @(negedge clk);
        end
        wr_data_req = 1'b0;
        key_vld = 1'b0;
        chk("wr_addr_stable", wr_addr, m_base);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        if (nwords != BL) m_err = 1;
        m_next_rd = 1;
        chk("busy_after_wr", {31'd0, busy}, 0);
    endtask

    task automatic do_read(input int ack_dly, input int nwords, input int corrupt, input bit noise);
        key_vld = 1'b1;
        @(negedge clk);
        key_vld = 1'b0;
        chk("rd_req_rise", {31'd0, rd_req}, 1);
        chk("wr_req_idle_rd", {31'd0, wr_req}, 0);
        chk("rd_addr", rd_addr, m_base);
        for (int j = 0; j < ack_dly; j++) begin
            rd_done = noise && (j == 0);
            @(negedge clk);
            rd_done = 1'b0;
            chk("rd_req_hold", {31'd0, rd_req}, 1);
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        chk("rd_req_drop", {31'd0, rd_req}, 0);
        for (int i = 0; i < nwords; i++) begin
            rd_data_vld = 1'b1;
            rd_data = tpat(m_pass, i) ^ ((i == corrupt) ? 16'h0010 : 16'h0000);
            key_vld = noise && (i == 1);
            if (i == corrupt && i < BL) m_err = 1;
            @(negedge clk);
        end
        rd_data_vld = 1'b0;
        key_vld = 1'b0;
        rd_data = '0;
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        if (nwords != BL) m_err = 1;
        m_next_rd = 0;
        m_pass++;
`ifdef KEY_SDRAM_TESTER_ADDR_INC_EN
        m_base = m_base + BL;
`endif
        chk("busy_after_rd", {31'd0, busy}, 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 3, 8, -1, 0, 0, 1};
        vecs[1] = '{1, 1, 8, -1, 0, 0, 0};
        vecs[2] = '{0, 0, 8, -1, 1, 0, 1};
        vecs[3] = '{1, 2, 8,  3, 1, 1, 0};
        vecs[4] = '{0, 1, 8, -1, 0, 1, 1};
        vecs[5] = '{1, 0, 8, -1, 0, 1, 0};

        rst_n = 1'b0; key_vld = 0; wr_ack = 0; wr_data_req = 0; wr_done = 0;
        rd_ack = 0; rd_data_vld = 0; rd_done = 0; rd_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_outputs", {err, next_rd, busy, rd_req, wr_req}, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_addr", wr_addr | rd_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 0);

        // stray acks and dones in IDLE must not start anything
        wr_ack = 1; rd_ack = 1; wr_done = 1; rd_done = 1;
        @(negedge clk);
        wr_ack = 0; rd_ack = 0; wr_done = 0; rd_done = 0;
        chk("stray_idle", {err, next_rd, busy, rd_req, wr_req}, 0);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_rd) do_read(vecs[v].ack_dly, vecs[v].nwords, vecs[v].corrupt, vecs[v].noise);
            else               do_write(vecs[v].ack_dly, vecs[v].nwords, vecs[v].noise);
            chk($sformatf("vec%0d_err", v), {31'd0, err}, {31'd0, vecs[v].exp_err});
            chk($sformatf("vec%0d_next_rd", v), {31'd0, next_rd}, {31'd0, vecs[v].exp_next_rd});
        end

        // short read burst
        apply_reset();
        do_write(0, BL, 0);
        chk("clean_write_err", {31'd0, err}, 0);
        do_read(0, BL - 1, -1, 0);
        chk("short_read_err", {31'd0, err}, 1);

        // write overrun: ninth request repeats last word
        apply_reset();
        do_write(2, BL + 1, 0);
        chk("overrun_write_err", {31'd0, err}, 1);
        chk("overrun_next_rd", {31'd0, next_rd}, 1);

        // reset in the middle of a write burst
        apply_reset();
        do_write(0, BL, 0);
        do_read(0, BL, 5, 0);
        key_vld = 1;
        @(negedge clk);
        key_vld = 0;
        wr_ack = 1;
        @(negedge clk);
        wr_ack = 0;
        wr_data_req = 1;
        repeat (3) @(negedge clk);
        wr_data_req = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {err, next_rd, busy, rd_req, wr_req}, 0);
        chk("midrst_wr_data", wr_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        do_write(1, BL, 0);
        chk("after_rst_err", {31'd0, err}, 0);

        // randomized steps against the model
        for (int s = 0; s < 40; s++) begin
            int dly, nw, cor;
            bit nz;
            dly = $urandom_range(0, 3);
            nw  = ($urandom_range(0, 5) == 0) ? BL - 1 + 2 * $urandom_range(0, 1) : BL;
            cor = ($urandom_range(0, 4) == 0) ? $urandom_range(0, BL - 1) : -1;
            nz  = 1'($urandom_range(0, 1));
            if (s == 20) apply_reset();
            if (m_next_rd) do_read(dly, nw, cor, nz);
            else           do_write(dly, nw, nz);
            chk("rand_err", {31'd0, err}, {31'd0, m_err});
            chk("rand_next_rd", {31'd0, next_rd}, {31'd0, m_next_rd});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
